// File: rtl/nios2_mult_pipe.sv
// Pipelined split-operand multiplier for MUL/MULXUU/MULXSU/MULXSS with valid/ready, flush and tag.
// Define MULT_PIPE_OUTREG_EN to add an output register stage after result select (latency 3 instead of 2).
module nios2_mult_pipe #(
  parameter int DATA_W = 32,
  parameter int TAG_W  = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] src1,
  input  logic [DATA_W-1:0] src2,
  input  logic [1:0]        op,
  input  logic [TAG_W-1:0]  in_tag,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] result,
  output logic [TAG_W-1:0]  out_tag
);

  localparam int H = DATA_W / 2;

  localparam logic [1:0] OP_MUL    = 2'b00;
  localparam logic [1:0] OP_MULXUU = 2'b01;
  localparam logic [1:0] OP_MULXSU = 2'b10;
  localparam logic [1:0] OP_MULXSS = 2'b11;

  logic stall;
  logic accept;

  // Stage 1: partial products plus operands kept for the signed correction
  logic              s1_valid;
  logic [DATA_W-1:0] s1_pp_ll;
  logic [DATA_W-1:0] s1_pp_lh;
  logic [DATA_W-1:0] s1_pp_hl;
  logic [DATA_W-1:0] s1_pp_hh;
  logic [DATA_W-1:0] s1_a;
  logic [DATA_W-1:0] s1_b;
  logic [1:0]        s1_op;
  logic [TAG_W-1:0]  s1_tag;

  // Stage 2: selected result word
  logic              s2_valid;
  logic [DATA_W-1:0] s2_result;
  logic [TAG_W-1:0]  s2_tag;

  logic [H-1:0]        a_lo;
  logic [H-1:0]        a_hi;
  logic [H-1:0]        b_lo;
  logic [H-1:0]        b_hi;
  logic [2*DATA_W-1:0] mid_sum;
  logic [2*DATA_W-1:0] p_full;
  logic [DATA_W-1:0]   p_hi;
  logic [DATA_W-1:0]   corr_a;
  logic [DATA_W-1:0]   corr_b;
  logic [DATA_W-1:0]   sel_result;

  assign stall    = out_valid & ~out_ready;
  assign in_ready = ~stall & ~reset;
  assign accept   = in_valid & in_ready;

  assign a_lo = src1[H-1:0];
  assign a_hi = src1[DATA_W-1:H];
  assign b_lo = src2[H-1:0];
  assign b_hi = src2[DATA_W-1:H];

  // Operand capture only on accept so undriven inputs never enter the datapath
  always_ff @(posedge clk) begin
    if (!stall && accept) begin
      s1_pp_ll <= {{H{1'b0}}, a_lo} * {{H{1'b0}}, b_lo};
      s1_pp_lh <= {{H{1'b0}}, a_lo} * {{H{1'b0}}, b_hi};
      s1_pp_hl <= {{H{1'b0}}, a_hi} * {{H{1'b0}}, b_lo};
      s1_pp_hh <= {{H{1'b0}}, a_hi} * {{H{1'b0}}, b_hi};
      s1_a     <= src1;
      s1_b     <= src2;
      s1_op    <= op;
      s1_tag   <= in_tag;
    end
  end

  always_comb begin
    mid_sum = {{DATA_W{1'b0}}, s1_pp_lh} + {{DATA_W{1'b0}}, s1_pp_hl};
    p_full  = {{DATA_W{1'b0}}, s1_pp_ll} + (mid_sum << H) + {s1_pp_hh, {DATA_W{1'b0}}};
    p_hi    = p_full[2*DATA_W-1:DATA_W];
    corr_a  = s1_a[DATA_W-1] ? s1_b : '0;
    corr_b  = s1_b[DATA_W-1] ? s1_a : '0;
    sel_result = '0;
    case (s1_op)
      OP_MUL:    sel_result = p_full[DATA_W-1:0];
      OP_MULXUU: sel_result = p_hi;
      OP_MULXSU: sel_result = p_hi - corr_a;
      OP_MULXSS: sel_result = p_hi - corr_a - corr_b;
      default:   sel_result = '0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s2_result <= '0;
      s2_tag    <= '0;
    end else if (!stall && s1_valid) begin
      s2_result <= sel_result;
      s2_tag    <= s1_tag;
    end
  end

`ifdef MULT_PIPE_OUTREG_EN
  logic              s3_valid;
  logic [DATA_W-1:0] s3_result;
  logic [TAG_W-1:0]  s3_tag;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_valid <= 1'b0;
      s2_valid <= 1'b0;
      s3_valid <= 1'b0;
    end else if (flush) begin
      s1_valid <= 1'b0;
      s2_valid <= 1'b0;
      s3_valid <= 1'b0;
    end else if (!stall) begin
      s1_valid <= accept;
      s2_valid <= s1_valid;
      s3_valid <= s2_valid;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s3_result <= '0;
      s3_tag    <= '0;
    end else if (!stall && s2_valid) begin
      s3_result <= s2_result;
      s3_tag    <= s2_tag;
    end
  end

  assign out_valid = s3_valid;
  assign result    = s3_result;
  assign out_tag   = s3_tag;
`else
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_valid <= 1'b0;
      s2_valid <= 1'b0;
    end else if (flush) begin
      s1_valid <= 1'b0;
      s2_valid <= 1'b0;
    end else if (!stall) begin
      s1_valid <= accept;
      s2_valid <= s1_valid;
    end
  end

  assign out_valid = s2_valid;
  assign result    = s2_result;
  assign out_tag   = s2_tag;
`endif

endmodule

// File: tb/tb_nios2_mult_pipe.sv
// Self-checking bench for nios2_mult_pipe: directed table, stall/flush/reset sequences, random scoreboard.
// Latency expectation follows MULT_PIPE_OUTREG_EN.
module tb_nios2_mult_pipe;

`ifdef MULT_PIPE_OUTREG_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 2;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] src1;
  logic [31:0] src2;
  logic [1:0]  op;
  logic [4:0]  in_tag;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic [4:0]  out_tag;

  int nchecks = 0;
  int nerrs   = 0;

  typedef struct {
    logic [31:0] res;
    logic [4:0]  tag;
  } exp_t;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [1:0]  op;
    logic [4:0]  tag;
    logic [31:0] exp;
  } vec_t;

  exp_t       exp_q[$];
  logic [4:0] ret_tags[$];
  vec_t       tbl[10];

  nios2_mult_pipe #(.DATA_W(32), .TAG_W(5)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .src1(src1), .src2(src2), .op(op), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .out_tag(out_tag)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    nchecks++;
    if (act !== exp) begin
      nerrs++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Full-width signed/unsigned product, then pick the word the op asks for
  function automatic logic [31:0] ref_mul(input logic [31:0] a, input logic [31:0] b, input logic [1:0] o);
    longint sa, sb, ua, ub;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = longint'({32'b0, a});
    ub = longint'({32'b0, b});
    case (o)
      2'd0, 2'd1: p = ua * ub;
      2'd2:       p = sa * ub;
      default:    p = sa * sb;
    endcase
    return (o == 2'd0) ? p[31:0] : p[63:32];
  endfunction

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 5))
      0: return 32'h0000_0000;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'h7FFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  // Scoreboard: predicts retirements from accepted ops
  always @(negedge clk) begin
    exp_t e;
    if (reset) begin
      exp_q.delete();
    end else begin
      chk("in_ready_rule", {63'b0, in_ready}, {63'b0, !(out_valid && !out_ready)});
      if (flush) begin
        exp_q.delete();
      end else begin
        if (out_valid && exp_q.size() == 0) begin
          nchecks++;
          nerrs++;
          $display("FAIL spurious_out: got out_valid=1 tag=%0d expected no pending op at %0t", out_tag, $time);
        end else if (out_valid && out_ready) begin
          e = exp_q.pop_front();
          chk("sb_result", {32'b0, result}, {32'b0, e.res});
          chk("sb_tag", {59'b0, out_tag}, {59'b0, e.tag});
          ret_tags.push_back(out_tag);
        end
        if (in_valid && in_ready)
          exp_q.push_back('{ref_mul(src1, src2, op), in_tag});
      end
    end
  end

  task automatic send(input logic [31:0] a, input logic [31:0] b, input logic [1:0] o, input logic [4:0] t);
    int n;
    logic acc;
    n = 0;
    acc = 1'b0;
    src1 = a; src2 = b; op = o; in_tag = t; in_valid = 1'b1;
    do begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
      n++;
    end while (!acc && n < 100);
    in_valid = 1'b0;
    op = ~o;
    if (!acc) begin
      nchecks++;
      nerrs++;
      $display("FAIL send_timeout: got no in_ready expected accept within 100 cycles");
    end
  endtask

  task automatic send_check(input logic [31:0] a, input logic [31:0] b, input logic [1:0] o,
                            input logic [4:0] t, input logic [31:0] exp);
    send(a, b, o, t);
    for (int k = 1; k <= LAT; k++) begin
      @(negedge clk);
      if (k < LAT) begin
        chk("lat_early_valid", {63'b0, out_valid}, 64'd0);
        @(posedge clk);
        #1;
      end else begin
        chk("lat_valid", {63'b0, out_valid}, 64'd1);
        chk("dir_result", {32'b0, result}, {32'b0, exp});
        chk("dir_tag", {59'b0, out_tag}, {59'b0, t});
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    src1 = '0; src2 = '0; op = '0; in_tag = '0;

    tbl[0] = '{32'h0001_0003, 32'h0002_0005, 2'd0, 5'd1,  32'h000B_000F};
    tbl[1] = '{32'h0001_0003, 32'h0002_0005, 2'd1, 5'd2,  32'h0000_0002};
    tbl[2] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 2'd1, 5'd3,  32'hFFFF_FFFE};
    tbl[3] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 2'd3, 5'd4,  32'h0000_0000};
    tbl[4] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 2'd0, 5'd5,  32'h0000_0001};
    tbl[5] = '{32'hFFFF_FFFF, 32'h0000_0002, 2'd2, 5'd6,  32'hFFFF_FFFF};
    tbl[6] = '{32'h8000_0000, 32'h8000_0000, 2'd3, 5'd7,  32'h4000_0000};
    tbl[7] = '{32'h8000_0000, 32'hFFFF_FFFF, 2'd2, 5'd8,  32'h8000_0000};
    tbl[8] = '{32'h7FFF_FFFF, 32'h8000_0000, 2'd3, 5'd9,  32'hC000_0000};
    tbl[9] = '{32'h1234_5678, 32'h0000_0010, 2'd0, 5'd10, 32'h2345_6780};

    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", {63'b0, out_valid}, 64'd0);
    chk("rst_result", {32'b0, result}, 64'd0);
    chk("rst_out_tag", {59'b0, out_tag}, 64'd0);
    reset = 1'b0;
    @(negedge clk);
    chk("rst_in_ready", {63'b0, in_ready}, 64'd1);
    @(posedge clk);
    #1;

    for (int i = 0; i < 10; i++)
      send_check(tbl[i].a, tbl[i].b, tbl[i].op, tbl[i].tag, tbl[i].exp);

    // Back-to-back stream with a five-cycle stall in the middle
    ret_tags.delete();
    fork
      begin
        for (int t = 0; t < 8; t++)
          send(pick_operand(), pick_operand(), 2'($urandom), 5'(t));
      end
      begin
        repeat (4) @(posedge clk);
        #1 out_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("stall_out_valid", {63'b0, out_valid}, 64'd1);
        chk("stall_in_ready", {63'b0, in_ready}, 64'd0);
        repeat (3) @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join
    for (int n = 0; n < 40 && ret_tags.size() < 8; n++) @(posedge clk);
    #1;
    chk("stream_count", 64'(ret_tags.size()), 64'd8);
    for (int i = 0; i < 8 && i < ret_tags.size(); i++)
      chk("stream_order", {59'b0, ret_tags[i]}, 64'(i));
    repeat (4) @(posedge clk);
    #1;

    // Flush with two ops in flight plus one accepted in the flush cycle
    src1 = 32'h11; src2 = 32'h22; op = 2'd0; in_tag = 5'd20; in_valid = 1'b1;
    @(posedge clk); #1;
    in_tag = 5'd21;
    @(posedge clk); #1;
    in_tag = 5'd22; flush = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; flush = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("flush_no_valid", {63'b0, out_valid}, 64'd0);
    end
    @(posedge clk); #1;
    send_check(32'h0001_0003, 32'h0002_0005, 2'd0, 5'd23, 32'h000B_000F);

    // Asynchronous reset mid-stream
    for (int i = 0; i < 4; i++) begin
      src1 = 32'd3; src2 = 32'd5; op = 2'd0; in_tag = 5'(24 + i); in_valid = 1'b1;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    @(negedge clk);
    chk("pre_reset_valid", {63'b0, out_valid}, 64'd1);
    #3 reset = 1'b1;
    #1;
    chk("async_rst_valid", {63'b0, out_valid}, 64'd0);
    chk("async_rst_result", {32'b0, result}, 64'd0);
    chk("async_rst_tag", {59'b0, out_tag}, 64'd0);
    repeat (2) @(posedge clk);
    #3 reset = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("post_rst_no_valid", {63'b0, out_valid}, 64'd0);
    end
    @(posedge clk); #1;
    send_check(32'hFFFF_FFFF, 32'h0000_0002, 2'd2, 5'd30, 32'hFFFF_FFFF);

    // Random traffic with backpressure and occasional flush
    for (int c = 0; c < 1500; c++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      src1      = pick_operand();
      src2      = pick_operand();
      op        = 2'($urandom);
      in_tag    = 5'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      flush     = ($urandom_range(0, 39) == 0);
      @(posedge clk); #1;
    end
    in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    chk("drain_empty", 64'(exp_q.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrs);
    $finish;
  end

endmodule
